// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with synchronous clear, parallel load and enable.
// Provides a combinational terminal-count output for cascading stages, a
// registered wrap pulse, a registered out-of-range load flag and an optional
// one-shot mode that halts at the terminal state until cleared or reloaded.
module modn_updown_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 12,
  parameter int     ONE_SHOT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             load_err
);

  // Largest modulus the count register can represent.
  localparam longint MOD_LIMIT = longint'(1) << WIDTH;

  // Parameter sanity: stop elaboration on configurations that cannot work.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "modn_updown_counter: WIDTH=%0d outside 1..32", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > MOD_LIMIT) begin : g_bad_modulus
      $fatal(1, "modn_updown_counter: MODULUS=%0d outside 2..%0d", MODULUS, MOD_LIMIT);
    end
    if (ONE_SHOT != 0 && ONE_SHOT != 1) begin : g_bad_one_shot
      $fatal(1, "modn_updown_counter: ONE_SHOT=%0d must be 0 or 1", ONE_SHOT);
    end
  endgenerate

  // MODULUS fits in WIDTH+1 bits even when it equals 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT     = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_EXT     = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] TOP         = WIDTH'(MODULUS - 1);
  localparam logic             ONE_SHOT_EN = (ONE_SHOT != 0);

  // Architectural state.
  logic [WIDTH-1:0] count_p0;
  logic             wrap_p0;
  logic             done_p0;
  logic             load_err_p0;

  // Next-state values.
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             done_nxt;
  logic             load_err_nxt;

  // Extended arithmetic and terminal detection.
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;
  logic           at_top;
  logic           at_bottom;
  logic           at_term;
  logic           load_ok;

  // Modular step: terminal state folds back to the opposite end of the range.
  function automatic logic [WIDTH-1:0] step_mod(input logic             dir_up,
                                                input logic             term,
                                                input logic [WIDTH-1:0] inc_val,
                                                input logic [WIDTH-1:0] dec_val);
    if (term) begin
      return dir_up ? '0 : TOP;
    end
    return dir_up ? inc_val : dec_val;
  endfunction

  // Terminal detection from WIDTH+1-bit increment/decrement; the borrow bit flags count==0.
  always_comb begin
    inc_ext   = {1'b0, count_p0} + ONE_EXT;
    dec_ext   = {1'b0, count_p0} - ONE_EXT;
    at_top    = (inc_ext == MOD_EXT);
    at_bottom = dec_ext[WIDTH];
    at_term   = up_dn ? at_top : at_bottom;
    load_ok   = ({1'b0, load_val} < MOD_EXT);
  end

  // Next-state selection with priority clr > load > en; one-shot halts at the terminal state.
  always_comb begin
    count_nxt    = count_p0;
    done_nxt     = done_p0;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (clr) begin
      count_nxt = '0;
      done_nxt  = 1'b0;
    end else if (load) begin
      done_nxt = 1'b0;
      if (load_ok) begin
        count_nxt = load_val;
      end else begin
        count_nxt    = '0;
        load_err_nxt = 1'b1;
      end
    end else if (en && !done_p0) begin
      if (at_term && ONE_SHOT_EN) begin
        done_nxt = 1'b1;
      end else begin
        count_nxt = step_mod(up_dn, at_term, inc_ext[WIDTH-1:0], dec_ext[WIDTH-1:0]);
        wrap_nxt  = at_term;
      end
    end
  end

  // State register with asynchronous clear of count and all status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_p0    <= '0;
      wrap_p0     <= 1'b0;
      done_p0     <= 1'b0;
      load_err_p0 <= 1'b0;
    end else begin
      count_p0    <= count_nxt;
      wrap_p0     <= wrap_nxt;
      done_p0     <= done_nxt;
      load_err_p0 <= load_err_nxt;
    end
  end

  // Stored count never leaves 0..MODULUS-1.
  a_count_in_range : assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count_p0} < MOD_EXT));

  assign count    = count_p0;
  assign wrap     = wrap_p0;
  assign done     = ONE_SHOT_EN ? done_p0 : 1'b0;
  assign load_err = load_err_p0;
  // Terminal count is gated by reset so a cascaded stage never sees a spurious enable.
  assign tc       = ~rst & en & at_term & ~done_p0;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: several configurations share one stimulus
// stream and are compared every cycle against an arithmetic model, with a
// set of hand-computed expectations for the main scenarios.
module tb_modn_updown_counter;

  typedef struct packed {
    logic [31:0] count;
    logic        wrap;
    logic        done;
    logic        lerr;
  } st_t;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       clr     = 1'b0;
  logic       load    = 1'b0;
  logic       en      = 1'b0;
  logic       up_dn   = 1'b0;
  logic       casc_en = 1'b0;
  logic [3:0] lv      = 4'd0;

  logic [3:0] cnt_a, cnt_b, cnt_lo, cnt_hi;
  logic [2:0] cnt_c;
  logic tc_a, wrap_a, done_a, lerr_a;
  logic tc_b, wrap_b, done_b, lerr_b;
  logic tc_c, wrap_c, done_c, lerr_c;
  logic tc_lo, wrap_lo, done_lo, lerr_lo;
  logic tc_hi, wrap_hi, done_hi, lerr_hi;

  int errors = 0;
  int checks = 0;

  st_t ma, mb, mc;
  int  casc_n;

  always #5 clk = ~clk;

  // Default configuration: mod-12, wrapping.
  modn_updown_counter #(.WIDTH(4), .MODULUS(12), .ONE_SHOT(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv), .en(en), .up_dn(up_dn),
    .count(cnt_a), .tc(tc_a), .wrap(wrap_a), .done(done_a), .load_err(lerr_a));

  // One-shot mod-5.
  modn_updown_counter #(.WIDTH(4), .MODULUS(5), .ONE_SHOT(1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv), .en(en), .up_dn(up_dn),
    .count(cnt_b), .tc(tc_b), .wrap(wrap_b), .done(done_b), .load_err(lerr_b));

  // Full-range modulus (MODULUS == 2**WIDTH).
  modn_updown_counter #(.WIDTH(3), .MODULUS(8), .ONE_SHOT(0)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[2:0]), .en(en), .up_dn(up_dn),
    .count(cnt_c), .tc(tc_c), .wrap(wrap_c), .done(done_c), .load_err(lerr_c));

  // Two-digit decimal cascade.
  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(0)) dut_lo (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0), .en(casc_en), .up_dn(1'b1),
    .count(cnt_lo), .tc(tc_lo), .wrap(wrap_lo), .done(done_lo), .load_err(lerr_lo));

  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(0)) dut_hi (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0), .en(tc_lo), .up_dn(1'b1),
    .count(cnt_hi), .tc(tc_hi), .wrap(wrap_hi), .done(done_hi), .load_err(lerr_hi));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one clock edge of a modulo-m counter, expressed with % arithmetic.
  function automatic st_t model_step(st_t s, logic c, logic l, int v, logic e, logic u,
                                     int m, bit os);
    st_t n;
    int  nc;
    bit  crossed;
    n      = s;
    n.wrap = 1'b0;
    n.lerr = 1'b0;
    if (c) begin
      n.count = 0;
      n.done  = 1'b0;
    end else if (l) begin
      n.done  = 1'b0;
      n.count = (v < m) ? v : 0;
      n.lerr  = (v >= m);
    end else if (e && !s.done) begin
      nc      = (int'(s.count) + (u ? 1 : m - 1)) % m;
      crossed = u ? (nc == 0) : (nc == m - 1);
      if (crossed && os) begin
        n.done = 1'b1;
      end else begin
        n.count = nc;
        n.wrap  = crossed;
      end
    end
    return n;
  endfunction

  // Reference terminal count: the next enabled edge would cross the range boundary.
  function automatic logic model_tc(st_t s, logic r, logic e, logic u, int m);
    int nc;
    nc = (int'(s.count) + (u ? 1 : m - 1)) % m;
    return !r && e && !s.done && (u ? (nc == 0) : (nc == m - 1));
  endfunction

  // Model state advance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma     <= '0;
      mb     <= '0;
      mc     <= '0;
      casc_n <= 0;
    end else begin
      ma <= model_step(ma, clr, load, int'(lv), en, up_dn, 12, 1'b0);
      mb <= model_step(mb, clr, load, int'(lv), en, up_dn, 5, 1'b1);
      mc <= model_step(mc, clr, load, int'(lv[2:0]), en, up_dn, 8, 1'b0);
      if (casc_en) casc_n <= casc_n + 1;
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    check("a_count", cnt_a, ma.count);
    check("a_wrap", wrap_a, ma.wrap);
    check("a_done", done_a, ma.done);
    check("a_lerr", lerr_a, ma.lerr);
    check("a_tc", tc_a, model_tc(ma, rst, en, up_dn, 12));
    check("b_count", cnt_b, mb.count);
    check("b_wrap", wrap_b, mb.wrap);
    check("b_done", done_b, mb.done);
    check("b_lerr", lerr_b, mb.lerr);
    check("b_tc", tc_b, model_tc(mb, rst, en, up_dn, 5));
    check("c_count", cnt_c, mc.count);
    check("c_wrap", wrap_c, mc.wrap);
    check("c_tc", tc_c, model_tc(mc, rst, en, up_dn, 8));
    check("lo_count", cnt_lo, casc_n % 10);
    check("hi_count", cnt_hi, (casc_n / 10) % 10);
    check("lo_tc", tc_lo, !rst && casc_en && (casc_n % 10 == 9));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int up_seq[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 1};
  int os_seq[9]  = '{0, 1, 2, 3, 4, 4, 4, 4, 4};

  initial begin
    // Reset state, with en=1 and down selected so tc would be 1 if not gated by rst.
    en    = 1'b1;
    up_dn = 1'b0;
    tick();
    tick();
    check("rst_count_a", cnt_a, 0);
    check("rst_wrap_a", wrap_a, 0);
    check("rst_lerr_a", lerr_a, 0);
    check("rst_tc_a", tc_a, 0);

    // Count up from reset; one-shot instance halts at 4.
    up_dn = 1'b1;
    rst   = 1'b0;
    #1;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) tick();
      check("up_count_a", cnt_a, up_seq[i]);
      check("up_wrap_a", wrap_a, i == 12);
      check("up_tc_a", tc_a, i == 11);
      if (i < 9) begin
        check("os_count_b", cnt_b, os_seq[i]);
        check("os_done_b", done_b, i >= 5);
        check("os_tc_b", tc_b, i == 4);
        check("os_wrap_b", wrap_b, 0);
      end
    end
    load = 1'b1;
    lv   = 4'd2;
    tick();
    check("os_reload_count_b", cnt_b, 2);
    check("os_reload_done_b", done_b, 0);
    load = 1'b0;

    // Count down from reset.
    rst   = 1'b1;
    up_dn = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("dn_count_a0", cnt_a, 0);
    check("dn_tc_a0", tc_a, 1);
    tick();
    check("dn_count_a1", cnt_a, 11);
    check("dn_wrap_a1", wrap_a, 1);
    check("dn_tc_a1", tc_a, 0);
    check("dn_count_c1", cnt_c, 7);
    check("dn_wrap_c1", wrap_c, 1);
    tick();
    check("dn_count_a2", cnt_a, 10);
    check("dn_wrap_a2", wrap_a, 0);
    tick();
    check("dn_count_a3", cnt_a, 9);

    // Parallel load, out-of-range load, and clear priority.
    load  = 1'b1;
    lv    = 4'd7;
    up_dn = 1'b1;
    tick();
    check("ld_count_a", cnt_a, 7);
    check("ld_lerr_a", lerr_a, 0);
    load = 1'b0;
    tick();
    check("ld_next_a", cnt_a, 8);
    load = 1'b1;
    lv   = 4'd13;
    tick();
    check("ld_bad_count_a", cnt_a, 0);
    check("ld_bad_lerr_a", lerr_a, 1);
    load = 1'b0;
    en   = 1'b0;
    tick();
    check("ld_lerr_clear_a", lerr_a, 0);
    check("ld_hold_a", cnt_a, 0);
    clr  = 1'b1;
    load = 1'b1;
    lv   = 4'd5;
    en   = 1'b1;
    tick();
    check("clr_wins_count_a", cnt_a, 0);
    check("clr_wins_lerr_a", lerr_a, 0);
    lv = 4'd13;
    tick();
    check("clr_bad_lerr_a", lerr_a, 0);
    clr  = 1'b0;
    load = 1'b0;
    en   = 1'b0;

    // Decimal cascade for 105 cycles.
    rst     = 1'b1;
    casc_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (99) tick();
    check("casc99_hi", cnt_hi, 9);
    check("casc99_lo", cnt_lo, 9);
    check("casc99_tc", tc_lo, 1);
    repeat (6) tick();
    check("casc105_hi", cnt_hi, 0);
    check("casc105_lo", cnt_lo, 5);
    casc_en = 1'b0;

    // Asynchronous reset between edges.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    en    = 1'b1;
    up_dn = 1'b1;
    repeat (6) tick();
    check("ar_pre_count_a", cnt_a, 6);
    check("ar_pre_done_b", done_b, 1);
    #1 rst = 1'b1;
    #1;
    check("ar_count_a", cnt_a, 0);
    check("ar_wrap_a", wrap_a, 0);
    check("ar_lerr_a", lerr_a, 0);
    check("ar_tc_a", tc_a, 0);
    check("ar_done_b", done_b, 0);
    tick();
    rst = 1'b0;
    tick();
    check("ar_resume_a", cnt_a, 1);

    // Randomized operation.
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst   = ($urandom_range(0, 99) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      load  = ($urandom_range(0, 7) == 0);
      lv    = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) up_dn = ~up_dn;
      casc_en = ($urandom_range(0, 4) != 0);
    end
    rst  = 1'b0;
    clr  = 1'b0;
    load = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
Parametrised synchronous modulo-N counter with up/down count direction, parallel load, synchronous clear and enable. It has a terminal-count output for cascading stages and an optional one-shot (stop-at-terminal) mode. All flops share one clock, so there is no rippled clocking between bits. It is the general-purpose successor to our fixed mod-12 counter and serves as the building block for dividers, timers and BCD-style cascaded counters.

Parameters:
WIDTH, 4, bit width of count and load_val; legal range 1..32
MODULUS, 12, number of states; count range is 0..MODULUS-1; legal range 2..2**WIDTH
ONE_SHOT, 0, 0 = wrap at terminal; 1 = halt at terminal and hold done until clr or load

Ports:
clk       in   1      rising-edge clock; all state updates occur on this edge
rst       in   1      asynchronous, active-high reset
clr       in   1      synchronous clear to 0
load      in   1      synchronous parallel load of load_val
load_val  in   WIDTH  value to load
en        in   1      count enable
up_dn     in   1      1 = count up, 0 = count down
count     out  WIDTH  current count (registered)
tc        out  1      terminal count (combinational)
wrap      out  1      one-cycle pulse (registered): a wrap occurred on the last edge
done      out  1      ONE_SHOT only (registered): terminal reached; tied 0 when ONE_SHOT=0
load_err  out  1      one-cycle pulse (registered): out-of-range load was rejected

Behaviour:
- Reset: asynchronous and active-high; port names are clk and rst. While rst=1: count=0, wrap=0, done=0, load_err=0. Release of rst takes effect from the next clk edge.
- Control priority on each rising clk edge: clr > load > en. Inputs are sampled at the edge.
- clr=1:
  - count<=0, done<=0.
  - wrap and load_err go to 0.
- load=1 (clr=0):
  - If load_val < MODULUS: count<=load_val, done<=0.
  - If load_val >= MODULUS: count<=0, done<=0, and load_err pulses 1 for exactly that cycle.
  - wrap<=0.
- en=1, up_dn=1 (no clr/load):
  - If count==MODULUS-1 and ONE_SHOT=0: count<=0, wrap<=1.
  - If count==MODULUS-1 and ONE_SHOT=1: count holds, done<=1, wrap<=0.
  - Otherwise count<=count+1.
- en=1, up_dn=0 (no clr/load):
  - If count==0 and ONE_SHOT=0: count<=MODULUS-1, wrap<=1.
  - If count==0 and ONE_SHOT=1: count holds, done<=1, wrap<=0.
  - Otherwise count<=count-1.
- en=0 (no clr/load): count and done hold; wrap and load_err <= 0.
- tc (combinational) = en & (up_dn ? count==MODULUS-1 : count==0) & ~done.
  - Asserted in the cycle before the wrapping edge, so a cascaded stage uses it directly as its en.
  - Forced 0 while rst=1.
- Latency: count changes on the same edge that samples the control inputs. wrap, done and load_err are visible in the cycle after that edge, aligned with the new count.
- Direction changes mid-count take effect on the next enabled edge; no extra cycle is inserted.
- Once done=1 in ONE_SHOT mode, en is ignored until clr or load. A direction change does not restart counting.
- Arithmetic: count+1 and count-1 are computed at WIDTH+1 bits. Out-of-range values are never stored, so count < MODULUS always holds.
- MODULUS==2**WIDTH is legal and wraps naturally.
- Illegal parameters (MODULUS<2 or MODULUS>2**WIDTH) must be flagged by an elaboration-time check that stops the simulation.
- Reset asserted mid-count: outputs clear immediately, with no dependence on clk.

Test Plan:
- Defaults (W=4, M=12), rst pulse, then en=1, up_dn=1 for 13 cycles -> count 0,1,...,11,0,1; tc=1 only while count=11; wrap=1 only in the cycle count shows 0.
- up_dn=0 from reset, en=1 for 3 cycles -> count 0,11,10,9; wrap pulses once, when count=11; tc=1 while count=0.
- load=1, load_val=7, then en=1 -> count 7,8. Then load_val=13 -> count=0, load_err=1 for one cycle. Then clr=1, load=1, en=1 together -> count=0 (clr wins), load_err=0.
- ONE_SHOT=1, M=5, up, en=1 for 8 cycles -> count 0..4 then holds at 4; done=1 from the cycle after the 4->4 hold edge; tc=0 once done; wrap never pulses. Then load_val=2 -> done=0, count=2.
- Two instances cascaded (low en=1, high en=low.tc, M=10 each, W=4) for 105 cycles -> high.count=0, low.count=5 at cycle 105 (BCD 105 mod 100); high increments exactly when low goes 9->0.
- rst asserted asynchronously between edges at count=6 -> count=0 and wrap/done/load_err=0 before the next clk edge. After release, counting resumes from 0.
